// File: rtl/key_expand256_seq.sv
// AES-256 forward key expansion: streams round keys 0..14 over valid/ready,
// then publishes {rk13, rk14} as the starting key for the inverse expansion.

module aes_sbox_fwd (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign out_byte = affine(gf_inv(in_byte));
endmodule

module key_expand256_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key,
    input  logic         start,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic         busy,
    output logic         done,
    output logic [255:0] last_key,
    output logic [1:0]   state_dbg
);
    // Handshake: a round key transfers on any rising edge where rk_valid && rk_ready;
    // while rk_valid && !rk_ready the key, index, window and state all hold.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] w [8];

    logic [3:0]  next_idx;
    logic        even_step;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [7:0]  rcon;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign state_dbg = state;

    // Step parity follows the index being produced, not the one on the bus
    always_comb begin
        next_idx  = rk_idx + 4'd1;
        even_step = ~next_idx[0];
        sub_in    = even_step ? {w[7][23:0], w[7][31:24]} : w[7];
        rcon      = 8'h01 << (next_idx[3:1] - 3'd1);
        t         = sub_out ^ (even_step ? {rcon, 24'h000000} : 32'h00000000);
        n0        = w[0] ^ t;
        n1        = w[1] ^ n0;
        n2        = w[2] ^ n1;
        n3        = w[3] ^ n2;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox_fwd u_sbox (
            .in_byte  (sub_in[8*g +: 8]),
            .out_byte (sub_out[8*g +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_key <= '0;
            rk_idx    <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            last_key  <= '0;
            for (int i = 0; i < 8; i++) w[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 8; i++) w[i] <= key[255-32*i -: 32];
                        round_key <= key[255:128];
                        rk_idx    <= 4'd0;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_valid && rk_ready) begin
                        if (rk_idx == 4'd14) begin
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            last_key <= {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
                            state    <= FIN;
                        end else begin
                            rk_idx <= next_idx;
                            if (rk_idx == 4'd0) begin
                                // Round 1 is the cipher key's lower half; no step needed
                                round_key <= {w[4], w[5], w[6], w[7]};
                            end else begin
                                round_key <= {n0, n1, n2, n3};
                                w[0] <= w[4];
                                w[1] <= w[5];
                                w[2] <= w[6];
                                w[3] <= w[7];
                                w[4] <= n0;
                                w[5] <= n1;
                                w[6] <= n2;
                                w[7] <= n3;
                            end
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_expand256_seq.sv
// Bench for key_expand256_seq: FIPS-197 vectors, random keys and stalls,
// ignored start, mid-run reset and an inverse-expansion cross-check.

module tb_key_expand256_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] key = '0;
    logic         start = 1'b0;
    logic         rk_ready = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         busy;
    logic         done;
    logic [255:0] last_key;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    logic [131:0] exp_q[$];
    logic [255:0] exp_last = '0;
    logic [31:0]  mw [60];
    logic [127:0] obs_rk [16];

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    key_expand256_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .start     (start),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done),
        .last_key  (last_key),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [127:0] row;
        row = SBOX_ROWS[b[7:4]];
        return row[127 - 8*b[3:0] -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
    endfunction

    // Word-schedule temp for index i, given w[i-1]
    function automatic logic [31:0] temp_of(input int i, input logic [31:0] prev);
        if (i % 8 == 0)
            return sub_word({prev[23:0], prev[31:24]}) ^ (32'h01000000 << (i / 8 - 1));
        else if (i % 8 == 4)
            return sub_word(prev);
        else
            return prev;
    endfunction

    function automatic void expand(input logic [255:0] k);
        for (int i = 0; i < 8; i++) mw[i] = k[255-32*i -: 32];
        for (int i = 8; i < 60; i++) mw[i] = mw[i-8] ^ temp_of(i, mw[i-1]);
    endfunction

    // Walk the schedule backwards from w52..w59 to recover w0..w3
    function automatic logic [127:0] inverse_rk0(input logic [255:0] lk);
        logic [31:0] v [60];
        for (int i = 0; i < 60; i++) v[i] = '0;
        for (int i = 0; i < 8; i++) v[52+i] = lk[255-32*i -: 32];
        for (int i = 59; i >= 8; i--) v[i-8] = v[i] ^ temp_of(i, v[i-1]);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_round_key"}, round_key, 0);
        chk({tag, "_rk_idx"}, rk_idx, 0);
        chk({tag, "_rk_valid"}, rk_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_last_key"}, last_key, 0);
    endtask

    // Full run from mid-cycle before the accepting edge to mid-cycle after FIN
    task automatic run_key(input logic [255:0] k, input int stall_pct, input bit poke_start);
        int c;
        int stalls;
        int sent;
        bit poked;
        expand(k);
        exp_q.delete();
        for (int r = 0; r < 15; r++)
            exp_q.push_back({r[3:0], mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
        for (int r = 0; r < 16; r++) obs_rk[r] = 'x;
        start    = 1'b1;
        key      = k;
        rk_ready = ($urandom_range(0, 99) >= stall_pct);
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = rand_key();
        c = 0; stalls = 0; sent = 0; poked = 1'b0;
        while (sent < 15 && c < 200) begin
            @(negedge clk);
            c++;
            chk("rk_valid", rk_valid, 1);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("last_key_hold", last_key, exp_last);
            chk("round_key", {rk_idx, round_key}, exp_q.size() > 0 ? exp_q[0] : 'x);
            if (rk_ready) begin
                obs_rk[rk_idx] = round_key;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                sent++;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
            start    = 1'b0;
            rk_ready = ($urandom_range(0, 99) >= stall_pct);
            if (poke_start && !poked && sent == 5) begin
                start = 1'b1;
                key   = ~k;
                poked = 1'b1;
            end
        end
        chk("transfers", sent, 15);
        @(negedge clk);
        c++;
        exp_last = {mw[52], mw[53], mw[54], mw[55], mw[56], mw[57], mw[58], mw[59]};
        chk("done", done, 1);
        chk("rk_valid_fin", rk_valid, 0);
        chk("busy_fin", busy, 0);
        chk("last_key", last_key, exp_last);
        chk("done_cycle", c, 16 + stalls);
        chk("inverse_rk0", inverse_rk0(last_key), k[255:128]);
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int n;
        logic [255:0] k;

        // Reset values
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 A.3, consumer always ready
        run_key(KEY_A3, 0, 1'b0);
        chk("a3_rk0", obs_rk[0], 128'h603deb1015ca71be2b73aef0857d7781);
        chk("a3_rk1", obs_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
        chk("a3_rk2", obs_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("a3_rk3", obs_rk[3], 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        chk("a3_rk14", obs_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        chk("a3_last_low", last_key[127:0], 128'hfe4890d1e6188d0b046df344706c631e);

        // Same key with random stalls, then with a stray start at r=5
        run_key(KEY_A3, 40, 1'b0);
        chk("a3_stall_rk14", obs_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
        run_key(KEY_A3, 20, 1'b1);
        chk("a3_poke_rk2", obs_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);

        // Reset in the middle of a run at r=7
        start    = 1'b1;
        key      = rand_key();
        rk_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rk_idx != 4'd7 && n < 40);
        chk("reach_r7", rk_idx, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrun_reset");
        exp_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_key(rand_key(), 30, 1'b0);

        // All-zero key, twice back to back
        run_key('0, 0, 1'b0);
        chk("zero_rk2", obs_rk[2], 128'h62636363626363636263636362636363);
        run_key('0, 0, 1'b0);
        chk("zero_rk2_again", obs_rk[2], 128'h62636363626363636263636362636363);

        // Random keys with varying stall density
        for (int j = 0; j < 4; j++) begin
            k = rand_key();
            run_key(k, $urandom_range(0, 60), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_expand256_seq.md
# key_expand256_seq

Sequential AES-256 forward key-expansion engine for the encryption datapath. It is the encrypt-side counterpart of the decrypt-side inverse key expansion. It takes the 256-bit cipher key and streams the 15 round keys (round 0 to 14) in ascending order over a valid/ready handshake, one key per cycle when the consumer is ready. On completion it presents the final 256-bit expanded key (round keys 13 and 14) on `last_key`, which is the starting key the inverse expansion needs for decryption.

## Interface
Parameters: none (AES-256 fixed: Nk=8, Nr=14).

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `key`  in  256  cipher key; `key[255:224]` = w0 … `key[31:0]` = w7; sampled only on an accepted `start`
- `start`  in  1  request expansion; accepted only in IDLE, ignored otherwise
- `rk_ready`  in  1  consumer ready for `round_key`
- `round_key`  out  128  current round key; `[127:96]` = w[4r] … `[31:0]` = w[4r+3]
- `rk_idx`  out  4  round index r of `round_key`, 0..14
- `rk_valid`  out  1  `round_key` / `rk_idx` valid
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after round key 14 transfers
- `last_key`  out  256  {rk13, rk14}; updated when `done` pulses, held until the next `done`

## Operation
- State machine:
  - IDLE: on `start`, load `key` into an 8-word window W. Set `rk_idx`=0, `round_key`=W[0..3], `rk_valid`=1, `busy`=1, then go to EMIT.
  - EMIT: a transfer occurs when `rk_valid && rk_ready`.
    - If r<14 on a transfer: r←r+1 and a new `round_key` is registered in the same edge.
    - If r=14 on a transfer: go to FIN.
  - FIN: for one cycle, `done`=1, `rk_valid`=0, `busy`=0, `last_key` loaded. Then go to IDLE.
- Round-key sourcing:
  - r=1 comes from W[4..7].
  - r≥2 is produced by a 4-word step over W, using FIPS-197 rules:
    - first word: t = W[7] transformed, then n0 = W[0]^t.
    - following words: n1 = W[1]^n0, n2 = W[2]^n1, n3 = W[3]^n2.
    - W shifts left by 4 words; n0..n3 become W[4..7] and the new `round_key`.
  - Transform for even r: t = SubWord(RotWord(W[7])) ^ {Rcon[r/2], 24'h0}, with Rcon[1..7] = 01,02,04,08,10,20,40.
  - Transform for odd r: t = SubWord(W[7]) (no rotate, no Rcon).
  - SubWord uses 4 instances of the codebase's forward S-box. One step is combinational per cycle.
- Stall: while `rk_valid && !rk_ready`, `round_key`, `rk_idx`, W and state hold unchanged.
- `start` during EMIT or FIN is ignored; `key` changes mid-run have no effect.
- `rst_n` low at any time, including mid-run, forces IDLE immediately. The run is abandoned, `done` is not pulsed, and `last_key` keeps its reset value.

## Timing
- Reset values: `round_key`=0, `rk_idx`=0, `rk_valid`=0, `busy`=0, `done`=0, `last_key`=0, W=0.
- Latency: `start` accepted at edge N → `rk_valid`=1 with r=0 in cycle N+1.
- With `rk_ready` held high: r=0..14 appear in cycles N+1..N+15 with no bubbles. `done`=1 in cycle N+16; `start` can be accepted again in cycle N+17.
- Each cycle of `rk_ready` low adds exactly one cycle to the run.
- All outputs are registered; `round_key` has no combinational path from `rk_ready`.

## Test plan
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, `rk_ready`=1:
  - rk0 = 603deb10…857d7781, rk1 = 1f352c07…0914dff4
  - rk2 = 9ba35411 8e6925af a51a8b5f 2067fcde, rk3 = a8b09c1a 93d194cd be49846e b75d5b9a
  - rk14 = fe4890d1 e6188d0b 046df344 706c631e
  - `done` at cycle N+16; `last_key[127:0]` = rk14.
- Same key with `rk_ready` randomly deasserted: the key sequence is identical; outputs are stable during each stall; `done` is delayed by exactly the number of stall cycles.
- `start` pulsed at r=5 with a different `key`: ignored, and the sequence matches the first test.
- `rst_n` asserted at r=7: all outputs return to 0 asynchronously. A new `start` then restarts from r=0, and `last_key` stays 0 until that run completes.
- All-zero key: rk2 = 62636363 62636363 62636363 62636363. Back-to-back `start` in the cycle after `done` produces a second identical run.
- Cross-check: feed `last_key` into the inverse expansion and confirm it regenerates rk0 = the original key's upper half.
